// File: rtl/sample_fanout_ctrl.sv
// Holds one upstream sample and broadcasts it to every enabled consumer, with a stall timeout.
// Optional statistics counters: define SAMPLE_FANOUT_STATS_EN.
module sample_fanout_ctrl #(
   parameter int NUM_CONS      = 2,
   parameter int DATA_W        = 24,
   parameter int STALL_TIMEOUT = 1024,
   parameter int CNT_W         = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [DATA_W-1:0]   s_data_i,
   input  logic                s_valid_i,
   output logic                s_ready_o,
   input  logic [NUM_CONS-1:0] enable_i,
   output logic [DATA_W-1:0]   m_data_o,
   output logic [NUM_CONS-1:0] m_valid_o,
   input  logic [NUM_CONS-1:0] m_ready_i,
   output logic                drop_pulse_o
`ifdef SAMPLE_FANOUT_STATS_EN
   ,
   output logic [CNT_W-1:0]    accept_count_o,
   output logic [CNT_W-1:0]    drop_count_o
`endif
);

   localparam int TW = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] T_LAST = TW'((STALL_TIMEOUT > 0) ? STALL_TIMEOUT - 1 : 0);

   generate
      if (NUM_CONS < 1 || NUM_CONS > 8 || CNT_W < 1) begin : g_bad_param
         $error("sample_fanout_ctrl: NUM_CONS must be 1..8 and CNT_W >= 1");
      end
   endgenerate

   typedef enum logic {EMPTY, HOLD} state_t;

   state_t              state_q;
   logic [NUM_CONS-1:0] pending_q;
   logic [NUM_CONS-1:0] pend_nxt;
   logic [TW-1:0]       timer_q;
   logic [DATA_W-1:0]   hold_q;
   logic                timeout_hit;
   logic                up_hs;
   logic                drop_evt;

   // A consumer leaves the pending set by handshaking or by being disabled.
   assign pend_nxt    = pending_q & enable_i & ~m_ready_i;
   assign timeout_hit = (STALL_TIMEOUT > 0) && (timer_q == T_LAST);
   assign drop_evt    = (state_q == HOLD) && (pend_nxt != '0) && timeout_hit;

   // Gated by rst_ni so upstream sees not-ready for the whole reset interval.
   assign s_ready_o = rst_ni && (state_q == EMPTY);
   assign up_hs     = s_valid_i && s_ready_o;
   assign m_data_o  = hold_q;
   assign m_valid_o = (state_q == HOLD) ? (pending_q & enable_i) : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= EMPTY;
         pending_q    <= '0;
         timer_q      <= '0;
         hold_q       <= '0;
         drop_pulse_o <= 1'b0;
      end else begin
         drop_pulse_o <= 1'b0;
         case (state_q)
            EMPTY: begin
               if (s_valid_i) begin
                  hold_q    <= s_data_i;
                  pending_q <= enable_i;
                  timer_q   <= '0;
                  if (enable_i != '0) state_q <= HOLD;
               end
            end
            HOLD: begin
               if (pend_nxt == '0) begin
                  pending_q <= '0;
                  state_q   <= EMPTY;
               end else if (timeout_hit) begin
                  pending_q    <= '0;
                  state_q      <= EMPTY;
                  drop_pulse_o <= 1'b1;
               end else begin
                  pending_q <= pend_nxt;
                  if (STALL_TIMEOUT > 0) timer_q <= timer_q + TW'(1);
               end
            end
            default: state_q <= EMPTY;
         endcase
      end
   end

`ifdef SAMPLE_FANOUT_STATS_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         accept_count_o <= '0;
         drop_count_o   <= '0;
      end else begin
         if (up_hs && accept_count_o != '1) accept_count_o <= accept_count_o + CNT_W'(1);
         if (drop_evt && drop_count_o != '1) drop_count_o <= drop_count_o + CNT_W'(1);
      end
   end
`else
   logic unused_stats;
   assign unused_stats = up_hs ^ drop_evt;
`endif

endmodule

// File: tb/tb_sample_fanout_ctrl.sv
// Random + directed bench for sample_fanout_ctrl against a transaction-level reference model.
module tb_sample_fanout_ctrl;
   localparam int NC = 2;
   localparam int DW = 24;
   localparam int TO = 8;
   localparam int CW = 4;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic [DW-1:0] s_data_i = '0;
   logic          s_valid_i = 1'b0;
   logic          s_ready_o;
   logic [NC-1:0] enable_i = '0;
   logic [DW-1:0] m_data_o;
   logic [NC-1:0] m_valid_o;
   logic [NC-1:0] m_ready_i = '0;
   logic          drop_pulse_o;
`ifdef SAMPLE_FANOUT_STATS_EN
   logic [CW-1:0] accept_count_o;
   logic [CW-1:0] drop_count_o;
`endif

   sample_fanout_ctrl #(.NUM_CONS(NC), .DATA_W(DW), .STALL_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .s_data_i(s_data_i), .s_valid_i(s_valid_i),
      .s_ready_o(s_ready_o), .enable_i(enable_i), .m_data_o(m_data_o), .m_valid_o(m_valid_o),
      .m_ready_i(m_ready_i), .drop_pulse_o(drop_pulse_o)
`ifdef SAMPLE_FANOUT_STATS_EN
      , .accept_count_o(accept_count_o), .drop_count_o(drop_count_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: a sample is "held" while some consumers still owe a take.
   bit          r_hold;
   logic [DW-1:0] r_data;
   bit [NC-1:0] r_owed;
   int          r_age;
   bit          r_drop;
   int          r_acc;
   int          r_drp;
   int          n_drops_seen = 0;

   task automatic model_reset();
      r_hold = 0; r_data = '0; r_owed = '0; r_age = 0; r_drop = 0; r_acc = 0; r_drp = 0;
   endtask

   task automatic step(input bit sv, input logic [DW-1:0] sd, input logic [NC-1:0] en,
                       input logic [NC-1:0] rdy);
      bit [NC-1:0] left;
      @(negedge clk_i);
      s_valid_i = sv; s_data_i = sd; enable_i = en; m_ready_i = rdy;
      #1;
      chk("s_ready", 32'(s_ready_o), 32'(!r_hold));
      chk("m_valid", 32'(m_valid_o), r_hold ? 32'(r_owed & en) : 32'd0);
      chk("m_data", 32'(m_data_o), 32'(r_data));
      chk("drop_pulse", 32'(drop_pulse_o), 32'(r_drop));
`ifdef SAMPLE_FANOUT_STATS_EN
      chk("accept_count", 32'(accept_count_o), 32'(r_acc));
      chk("drop_count", 32'(drop_count_o), 32'(r_drp));
`endif
      if (r_drop) n_drops_seen++;
      r_drop = 0;
      if (!r_hold) begin
         if (sv) begin
            if (r_acc < (1 << CW) - 1) r_acc++;
            r_data = sd;
            if (en != '0) begin r_hold = 1; r_owed = en; r_age = 0; end
         end
      end else begin
         left = r_owed & en & ~rdy;
         if (left == '0) begin
            r_hold = 0; r_owed = '0;
         end else if (r_age + 1 == TO) begin
            r_hold = 0; r_owed = '0; r_drop = 1;
            if (r_drp < (1 << CW) - 1) r_drp++;
         end else begin
            r_owed = left; r_age++;
         end
      end
      @(posedge clk_i);
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      #1;
      chk("rst_s_ready", 32'(s_ready_o), 32'd0);
      chk("rst_m_valid", 32'(m_valid_o), 32'd0);
      model_reset();
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   initial begin
      logic [NC-1:0] en, rdy;
      model_reset();
      do_reset();

      // 1: full broadcast, both consumers ready
      step(1, 24'h123456, 2'b11, 2'b11);
      step(0, 24'h0, 2'b11, 2'b11);
      step(0, 24'h0, 2'b11, 2'b11);
      // 2: staggered consumers, data stable
      step(1, 24'hFFFFF0, 2'b11, 2'b00);
      step(0, 24'h0, 2'b11, 2'b01);
      repeat (3) step(0, 24'h0, 2'b11, 2'b00);
      step(0, 24'h0, 2'b11, 2'b10);
      step(0, 24'h0, 2'b11, 2'b00);
      // 3: cons1 hung -> timeout drop
      step(1, 24'h0ABCDE, 2'b11, 2'b01);
      repeat (TO + 2) step(0, 24'h0, 2'b11, 2'b00);
      // 4: cons1 handshakes exactly in the timeout cycle
      step(1, 24'h55AA55, 2'b11, 2'b01);
      repeat (TO - 1) step(0, 24'h0, 2'b11, 2'b00);
      step(0, 24'h0, 2'b11, 2'b10);
      step(0, 24'h0, 2'b11, 2'b00);
      // 5: no consumers enabled -> back-to-back accepts
      repeat (3) step(1, DW'($urandom), 2'b00, 2'b00);
      step(0, 24'h0, 2'b00, 2'b00);
      // 6: reset in the middle of a hold
      step(1, 24'h777777, 2'b11, 2'b00);
      step(0, 24'h0, 2'b11, 2'b00);
      #2;
      do_reset();
      step(0, 24'h0, 2'b11, 2'b00);

      // Random traffic: normal readiness, then a sluggish consumer, then random enables
      for (int i = 0; i < 1500; i++) begin
         en = (i < 1000) ? 2'b11 : NC'($urandom);
         if (i >= 200 && i < 1000 && ($urandom_range(0, 19) == 0)) en = 2'b01;
         rdy[0] = ($urandom_range(0, 1) == 1);
         rdy[1] = (i >= 300 && i < 1000) ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 1) == 1);
         step($urandom_range(0, 9) < 7, DW'($urandom), en, rdy);
      end
      chk("drops_observed", 32'(n_drops_seen > 1), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
